// File: rtl/spart_driver.sv
// spart_driver: bus master for the SPART register interface.
// Programs the baud divisor after reset (and whenever br_cfg changes), then
// echoes every received byte back to the transmitter through a small FIFO.
// Optional: define ECHO_UPCASE_EN to fold 'a'..'z' to upper case on capture.
module spart_driver #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  output logic       cfg_done,
  output logic       overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Divisor = CLK_HZ/(16*baud) - 1, truncated, fixed at elaboration.
  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800)  - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600)  - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  typedef enum logic [1:0] {
    CFG_LO = 2'b00,
    CFG_HI = 2'b01,
    RUN    = 2'b10
  } state_t;

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_4800;
      2'b01:   return DIV_9600;
      2'b10:   return DIV_19200;
      default: return DIV_38400;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      br_q;      // br_cfg registered every cycle
  logic [1:0]      cfg_q;     // selection actually programmed
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      mem [DEPTH];

  logic            bus_cs, bus_rw;
  logic [1:0]      bus_addr;
  logic [7:0]      wdata;
  logic            push, pop;
  logic            full, empty;
  logic [15:0]     div_live, div_held;
  logic [7:0]      push_data;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign div_live = divisor(br_cfg);
  assign div_held = divisor(cfg_q);

`ifdef ECHO_UPCASE_EN
  assign push_data = (databus >= 8'h61 && databus <= 8'h7A) ? (databus & 8'hDF) : databus;
`else
  assign push_data = databus;
`endif

  // Outputs are gated by rst so the bus is released the instant reset asserts,
  // even though the state register resets to CFG_LO.
  assign iocs    = rst & bus_cs;
  assign iorw    = ~rst | bus_rw;
  assign ioaddr  = rst ? bus_addr : ADDR_BUF;
  assign databus = (iocs && !iorw) ? wdata : 8'hzz;

  // Next-state and bus-cycle decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    bus_cs   = 1'b0;
    bus_rw   = 1'b1;
    bus_addr = ADDR_BUF;
    wdata    = 8'h00;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      CFG_LO: begin
        bus_cs   = 1'b1;
        bus_rw   = 1'b0;
        bus_addr = ADDR_DIV_LO;
        wdata    = div_live[7:0];
        state_d  = CFG_HI;
      end
      CFG_HI: begin
        bus_cs   = 1'b1;
        bus_rw   = 1'b0;
        bus_addr = ADDR_DIV_HI;
        wdata    = div_held[15:8];
        state_d  = RUN;
      end
      RUN: begin
        if (rda) begin
          // A receive always wins the bus; a pending echo waits a cycle.
          bus_cs   = 1'b1;
          bus_rw   = 1'b1;
          bus_addr = ADDR_BUF;
          push     = 1'b1;
        end else if (!empty && tbr) begin
          bus_cs   = 1'b1;
          bus_rw   = 1'b0;
          bus_addr = ADDR_BUF;
          wdata    = mem[rd_ptr];
          pop      = 1'b1;
        end else begin
          bus_addr = ADDR_STATUS;
        end
        if (br_q != cfg_q) state_d = CFG_LO;
      end
      default: state_d = CFG_LO;
    endcase
  end

  // State, configuration tracking, FIFO pointers/count and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      state_q  <= CFG_LO;
      br_q     <= 2'b00;
      cfg_q    <= 2'b00;
      cfg_done <= 1'b0;
      overrun  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_cfg;
      if (state_q == CFG_LO) cfg_q <= br_cfg;
      if (state_q == CFG_HI) cfg_done <= 1'b1;
      else if (state_q == RUN && state_d == CFG_LO) cfg_done <= 1'b0;
      if (push) begin
        if (full) begin
          overrun <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + (AW+1)'(1);
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - (AW+1)'(1);
      end
    end
  end

  // Echo FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count alone defines which entries are valid.
    if (push && !full) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed bench for spart_driver with a transaction-level
// scoreboard (expected echo queue, divisor arithmetic, overrun flag) checked on
// every cycle, plus literal expectations for the key scenarios.
module tb_spart_driver;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic       cfg_done, overrun;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_errors = 0;

  spart_driver #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr), .cfg_done(cfg_done), .overrun(overrun)
  );

  // SPART side: returns the receive buffer while the master reads address 00.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hzz;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_div(input logic [1:0] sel);
    int unsigned baud = 4800 << sel;
    return 16'(CLK_HZ / (16 * baud) - 1);
  endfunction

  function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
    if (b >= "a" && b <= "z") return b - 8'd32;
`endif
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: bytes accepted but not yet echoed, and the sticky overrun flag.
  logic [7:0] m_q[$];
  logic       m_over = 1'b0;

  initial begin : compare
    logic       wr;
    logic       due;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_q.delete();
        m_over = 1'b0;
      end else begin
        wr  = iocs && !iorw;
        due = !rda && tbr && (m_q.size() != 0) && !(wr && ioaddr[1]);
        d   = exp_div(br_cfg);
        check("sb_overrun", overrun, m_over);
        if (rda) begin
          check("sb_read_cycle", {iocs, iorw, ioaddr}, 4'b1100);
        end else if (wr && ioaddr == 2'b10) begin
          check("sb_div_lo", databus, d[7:0]);
        end else if (wr && ioaddr == 2'b11) begin
          check("sb_div_hi", databus, d[15:8]);
        end else if (due) begin
          check("sb_echo_cycle", {iocs, iorw, ioaddr}, 4'b1000);
          check("sb_echo_data", databus, m_q[0]);
          void'(m_q.pop_front());
        end else begin
          check("sb_idle", {iocs, iorw, ioaddr}, 4'b0101);
        end
        if (rda) begin
          if (m_q.size() < DEPTH) m_q.push_back(xform(rx_byte));
          else m_over = 1'b1;
        end
      end
    end
  end

  task automatic expect_cfg(input string name, input logic [7:0] lo, input logic [7:0] hi);
    logic found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      mid();
      if (iocs && !iorw && ioaddr == 2'b10) found = 1'b1;
      else step();
    end
    check({name, "_lo_seen"}, found, 1'b1);
    if (found) begin
      check({name, "_lo_data"}, databus, lo);
      check({name, "_done_low"}, cfg_done, 1'b0);
      step(); mid();
      check({name, "_hi_addr"}, ioaddr, 2'b11);
      check({name, "_hi_data"}, databus, hi);
      step(); mid();
      check({name, "_done_high"}, cfg_done, 1'b1);
    end
  endtask

  logic [7:0] t6_in  [3] = '{8'h62, 8'h7B, 8'h5A};
`ifdef ECHO_UPCASE_EN
  logic [7:0] t6_out [3] = '{8'h42, 8'h7B, 8'h5A};
`else
  logic [7:0] t6_out [3] = '{8'h62, 8'h7B, 8'h5A};
`endif

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iocs", iocs, 1'b0);
    check("rst_iorw", iorw, 1'b1);
    check("rst_ioaddr", ioaddr, 2'b00);
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // 1: divisor programming for 9600 baud
    rst = 1'b1;
    mid();
    check("t1_lo_cycle", {iocs, iorw, ioaddr}, 4'b1010);
    check("t1_lo_data", databus, 8'h8A);
    step(); mid();
    check("t1_hi_addr", ioaddr, 2'b11);
    check("t1_hi_data", databus, 8'h02);
    check("t1_done_low", cfg_done, 1'b0);
    step(); mid();
    check("t1_done_high", cfg_done, 1'b1);
    check("t1_idle", {iocs, ioaddr}, 3'b001);

    // 2: single echo
    step(); tbr = 1'b1; rda = 1'b1; rx_byte = 8'h41;
    mid();
    check("t2_read", {iocs, iorw, ioaddr}, 4'b1100);
    step(); rda = 1'b0;
    mid();
    check("t2_write", {iocs, iorw, ioaddr}, 4'b1000);
    check("t2_data", databus, 8'h41);
    step(); mid();
    check("t2_empty_idle", iocs, 1'b0);

    // 3: overflow with DEPTH=4
    step(); tbr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rda = 1'b1; rx_byte = 8'(8'h10 + i);
      mid(); step();
    end
    rda = 1'b0;
    mid();
    check("t3_overrun", overrun, 1'b1);
    step(); tbr = 1'b1;
    for (int j = 0; j < 4; j++) begin
      mid();
      check("t3_drain_write", {iocs, iorw, ioaddr}, 4'b1000);
      check("t3_drain_data", databus, 8'(8'h10 + j));
      step();
    end
    mid();
    check("t3_drained_idle", iocs, 1'b0);
    check("t3_overrun_sticky", overrun, 1'b1);

    // 4: read beats a pending write
    step(); tbr = 1'b0; rda = 1'b1; rx_byte = 8'h55;
    mid();
    step(); rda = 1'b1; rx_byte = 8'h66; tbr = 1'b1;
    mid();
    check("t4_read_wins", {iocs, iorw, ioaddr}, 4'b1100);
    step(); rda = 1'b0;
    mid();
    check("t4_first", databus, 8'h55);
    step(); mid();
    check("t4_second", databus, 8'h66);
    step(); mid();
    check("t4_idle", iocs, 1'b0);

    // 5: baud change 01 -> 11 with a receive in the detection cycle
    step(); tbr = 1'b0; br_cfg = 2'b11;
    mid();
    check("t5_done_before", cfg_done, 1'b1);
    step(); rda = 1'b1; rx_byte = 8'h77;
    mid();
    check("t5_read", {iocs, iorw, ioaddr}, 4'b1100);
    step(); rda = 1'b0;
    expect_cfg("t5", 8'hA1, 8'h00);
    step(); tbr = 1'b1;
    mid();
    check("t5_kept_byte", databus, 8'h77);

    // 4800 baud: widest divisor
    step(); tbr = 1'b0; br_cfg = 2'b00;
    mid(); step();
    expect_cfg("t5b", 8'h15, 8'h05);

    // 6: echo transform
    tbr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); rda = 1'b1; rx_byte = t6_in[i];
      mid();
      step(); rda = 1'b0;
      mid();
      check("t6_echo", databus, t6_out[i]);
    end

    // Mid-operation reset with a byte queued and overrun set
    step(); tbr = 1'b0; rda = 1'b1; rx_byte = 8'h33;
    mid();
    step(); rda = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mrst_iocs", iocs, 1'b0);
    check("mrst_iorw", iorw, 1'b1);
    check("mrst_ioaddr", ioaddr, 2'b00);
    check("mrst_cfg_done", cfg_done, 1'b0);
    check("mrst_overrun", overrun, 1'b0);
    step(); rst = 1'b1;
    mid();
    check("mrst_lo_data", databus, 8'h15);
    step(); mid();
    check("mrst_hi_data", databus, 8'h05);
    step(); tbr = 1'b1;
    mid();
    check("mrst_fifo_flushed", iocs, 1'b0);
    step(); mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
Bus-master controller for the SPART register interface.
- After reset, programs the 16-bit baud divisor from a 2-bit baud select.
- Then runs an echo loop: captures each received byte into a small FIFO and writes it back to the transmit buffer whenever the transmitter is ready.
- Sits beside the SPART at top level and is the sole driver of iocs/iorw/ioaddr and the write direction of databus.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz, used to compute divisor constants.
- DEPTH, 4, echo FIFO depth in bytes; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- iocs  out  1  SPART chip select
- iorw  out  1  1=read, 0=write
- ioaddr  out  2  register address: 00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  driven by this block only when iocs=1 and iorw=0, otherwise high-Z
- rda  in  1  one-cycle pulse; receive buffer is valid in the same cycle
- tbr  in  1  transmit buffer ready (level)
- cfg_done  out  1  high once both divisor bytes are written for the current br_cfg
- overrun  out  1  sticky; set when a byte arrives with the FIFO full

Behaviour:
- Reset (async, rst=0) sets:
  - state=CFG_LO, FIFO empty, pointers 0
  - iocs=0, iorw=1, ioaddr=00, databus high-Z
  - cfg_done=0, overrun=0
- Divisor = CLK_HZ/(16*baud) - 1, integer truncation, computed at elaboration. At 100 MHz: 4800→0x0515, 9600→0x028A, 19200→0x0144, 38400→0x00A1.
- States:
  - CFG_LO: one cycle; iocs=1, iorw=0, ioaddr=10, databus=div[7:0]. Next state CFG_HI.
  - CFG_HI: one cycle; iocs=1, iorw=0, ioaddr=11, databus=div[15:8]. Next state RUN. cfg_done goes to 1 at the exit edge.
  - RUN: echo loop.
- RUN, per cycle, highest priority first:
  1. rda=1:
     - Drive iocs=1, iorw=1, ioaddr=00 combinationally in the same cycle.
     - Capture databus into the FIFO at the clock edge.
     - If the FIFO is full, discard the byte and set overrun.
  2. FIFO not empty and tbr=1:
     - Drive iocs=1, iorw=0, ioaddr=00, databus=FIFO head.
     - Pop at the edge.
  3. Otherwise iocs=0, iorw=1, ioaddr=01 (bus idle).
- Simultaneous rda and tbr with a non-empty FIFO: the read wins; the write is deferred to the next eligible cycle.
- Simultaneous push and pop cannot occur (single bus). Count changes by at most ±1 per cycle.
- FIFO pointers wrap modulo DEPTH. Full/empty are decided from an occupancy count of width clog2(DEPTH)+1.
- Echo latency: the byte captured at edge N appears on databus in cycle N+1 at the earliest, given tbr=1 and no rda in N+1.
- br_cfg is registered each cycle. Any change in RUN:
  - cfg_done←0 and next state CFG_LO.
  - FIFO contents are retained.
  - A pending rda in that same cycle is still captured.
- br_cfg is not re-sampled during CFG_LO/CFG_HI. A change there is detected on return to RUN.
- Reset mid-operation: immediate return to reset values; bus released asynchronously.
- overrun is cleared only by reset.

Optional Feature:
- Macro ECHO_UPCASE_EN.
- Defined: bytes 0x61–0x7A ('a'–'z') are converted to uppercase (bit 5 cleared) at FIFO push. All other bytes pass unchanged.
- Not defined: bytes are echoed unmodified.

Test Plan:
1. Reset release with br_cfg=01, CLK_HZ=100 MHz → write 0x8A at ioaddr 10 in cycle 1, write 0x02 at ioaddr 11 in cycle 2; cfg_done=1 in cycle 3.
2. RUN, tbr=1, rda pulse with rx byte 0x41 → read cycle at ioaddr 00 with rda; write of 0x41 at ioaddr 00 in the next cycle; FIFO empty afterwards.
3. tbr=0, five rda pulses (0x10–0x14), DEPTH=4 → 0x10–0x13 stored, 0x14 dropped, overrun=1. Then tbr=1 → writes 0x10, 0x11, 0x12, 0x13 in order; overrun stays 1.
4. FIFO holds 0x55, tbr=1, rda=1 with 0x66 in the same cycle → read occurs first; 0x55 then 0x66 written in the following two cycles.
5. In RUN, change br_cfg 01→11 → cfg_done drops; writes 0xA1 at ioaddr 10 then 0x00 at ioaddr 11; cfg_done returns to 1.
6. With ECHO_UPCASE_EN, rx 0x62, 0x7B, 0x5A → echoed 0x42, 0x7B, 0x5A. Without the macro → echoed 0x62, 0x7B, 0x5A.
